logic_op_pipe: RTL and testbench

Parametrised, pipelined bitwise logic unit for the ALU logic group, generalising the single-function XOR core.
- Eight selectable bitwise operations over OPERAND_WIDTH operands.
- Elastic valid/ready pipeline of STAGES registers with full back-pressure and a tag carried alongside each operation.
- Zero and parity flags on the result.
- Sits between ALU issue and writeback; sustains one operation per cycle when the sink is ready.

---
 rtl/logic_op_pkg.sv | 36 +++
 rtl/logic_op_stage.sv | 34 +++
 rtl/logic_op_pipe.sv | 86 ++++++++
 tb/tb_logic_op_pipe.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_op_pkg.sv
// Shared types and the bitwise operation evaluator for the ALU logic group.
// The evaluator works on a fixed maximum width; callers zero-extend and slice.
package logic_op_pkg;

  localparam int OP_WIDTH          = 3;
  localparam int MAX_OPERAND_WIDTH = 64;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_XNOR = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_ANDN = 3'd6,
    OP_NOT  = 3'd7
  } op_e;

  typedef logic [MAX_OPERAND_WIDTH-1:0] operand_t;

  function automatic operand_t logic_op_eval(op_e op, operand_t lhs, operand_t rhs);
    operand_t res;
    case (op)
      OP_AND:  res = lhs & rhs;
      OP_OR:   res = lhs | rhs;
      OP_XOR:  res = lhs ^ rhs;
      OP_XNOR: res = ~(lhs ^ rhs);
      OP_NAND: res = ~(lhs & rhs);
      OP_NOR:  res = ~(lhs | rhs);
      OP_ANDN: res = lhs & ~rhs;
      default: res = ~lhs;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/logic_op_stage.sv
// One elastic register slice: holds a valid bit and a payload, ready flows
// combinationally upstream so a downstream drain frees this slot in the same cycle.
module logic_op_stage #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [WIDTH-1:0] down_data
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  assign up_ready   = !valid_q || down_ready;
  assign down_valid = valid_q;
  assign down_data  = data_q;

  // Payload only loads on an actual transfer to keep data lines quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (up_ready) begin
      valid_q <= up_valid;
      if (up_valid) data_q <= up_data;
    end
  end

endmodule

// File: rtl/logic_op_pipe.sv
// Pipelined bitwise logic unit: evaluates one of eight ops on entry, then carries
// {result, tag} through STAGES elastic slices with full back-pressure.
module logic_op_pipe
  import logic_op_pkg::*;
#(
  parameter int OPERAND_WIDTH = 32,
  parameter int STAGES        = 2,
  parameter int TAG_WIDTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [OP_WIDTH-1:0]          in_op,
  input  logic [OPERAND_WIDTH-1:0]     in_lhs,
  input  logic [OPERAND_WIDTH-1:0]     in_rhs,
  input  logic [TAG_WIDTH-1:0]         in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OPERAND_WIDTH-1:0]     out_result,
  output logic                         out_zero,
  output logic                         out_parity,
  output logic [TAG_WIDTH-1:0]         out_tag,
  output logic [$clog2(STAGES+1)-1:0]  occupancy
);

  localparam int PW    = OPERAND_WIDTH + TAG_WIDTH;
  localparam int OCC_W = $clog2(STAGES + 1);

  operand_t                 lhs_ext;
  operand_t                 rhs_ext;
  operand_t                 res_full;
  logic [OPERAND_WIDTH-1:0] eval_result;

  always_comb begin
    lhs_ext = '0;
    rhs_ext = '0;
    lhs_ext[OPERAND_WIDTH-1:0] = in_lhs;
    rhs_ext[OPERAND_WIDTH-1:0] = in_rhs;
    res_full    = logic_op_eval(op_e'(in_op), lhs_ext, rhs_ext);
    eval_result = res_full[OPERAND_WIDTH-1:0];
  end

  generate
    if (OPERAND_WIDTH < MAX_OPERAND_WIDTH) begin : g_hi
      logic unused_res_hi;
      assign unused_res_hi = ^res_full[MAX_OPERAND_WIDTH-1:OPERAND_WIDTH];
    end
  endgenerate

  // Index k is the input side of stage k; index STAGES is the pipe output.
  logic [STAGES:0] st_valid;
  logic [STAGES:0] st_ready;
  logic [PW-1:0]   st_data [STAGES+1];

  assign st_valid[0]      = in_valid;
  assign st_data[0]       = {eval_result, in_tag};
  assign st_ready[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic_op_stage #(.WIDTH(PW)) u_stage (
      .clk        (clk),
      .rst        (rst),
      .up_valid   (st_valid[k]),
      .up_ready   (st_ready[k]),
      .up_data    (st_data[k]),
      .down_valid (st_valid[k+1]),
      .down_ready (st_ready[k+1]),
      .down_data  (st_data[k+1])
    );
  end

  assign in_ready  = st_ready[0] && !rst;
  assign out_valid = st_valid[STAGES];
  assign {out_result, out_tag} = st_data[STAGES];
  assign out_zero   = ~|out_result;
  assign out_parity = ^out_result;

  always_comb begin
    occupancy = '0;
    for (int k = 1; k <= STAGES; k++) begin
      occupancy = occupancy + OCC_W'(st_valid[k]);
    end
  end

endmodule

// File: tb/tb_logic_op_pipe.sv
// Directed bench for logic_op_pipe: a negedge monitor keeps a scoreboard of
// accepted operations and checks every emitted result, tag, flag and latency.
module tb_logic_op_pipe;

  localparam int W     = 32;
  localparam int S     = 2;
  localparam int TW    = 4;
  localparam int OCC_W = $clog2(S + 1);

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [W-1:0]     in_lhs;
  logic [W-1:0]     in_rhs;
  logic [TW-1:0]    in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_result;
  logic             out_zero;
  logic             out_parity;
  logic [TW-1:0]    out_tag;
  logic [OCC_W-1:0] occupancy;

  logic_op_pipe #(.OPERAND_WIDTH(W), .STAGES(S), .TAG_WIDTH(TW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_lhs     (in_lhs),
    .in_rhs     (in_rhs),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_parity (out_parity),
    .out_tag    (out_tag),
    .occupancy  (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit check_lat = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0]  res;
    logic [TW-1:0] tag;
    int            acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t push_e;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a ^ b);
      3'd4:    return ~(a & b);
      3'd5:    return ~(a | b);
      3'd6:    return a & ~b;
      default: return ~a;
    endcase
  endfunction

  // Monitor: pop/compare on an output handshake, push on an input handshake.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 64'(out_valid), 64'(1'b0));
        end else if (out_ready) begin
          mon_e = sb.pop_front();
          chk("sb_result", 64'(out_result), 64'(mon_e.res));
          chk("sb_tag", 64'(out_tag), 64'(mon_e.tag));
          chk("sb_zero", 64'(out_zero), 64'(mon_e.res == '0));
          chk("sb_parity", 64'(out_parity), 64'(^mon_e.res));
          if (check_lat) chk("sb_latency", 64'(cyc - mon_e.acc), 64'(S));
        end
      end
      if (in_valid && in_ready) begin
        push_e.res = ref_op(in_op, in_lhs, in_rhs);
        push_e.tag = in_tag;
        push_e.acc = cyc;
        sb.push_back(push_e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_lhs   = a;
    in_rhs   = b;
    in_tag   = tag;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < limit) begin
      step();
      n++;
    end
    chk("drain_done", 64'(sb.size() != 0 || out_valid), 64'(1'b0));
  endtask

  logic [W-1:0] sweep_exp [8] = '{32'h0000_0000, 32'h0000_00FF, 32'h0000_00FF, 32'hFFFF_FF00,
                                  32'hFFFF_FFFF, 32'hFFFF_FF00, 32'h0000_00C5, 32'hFFFF_FF3A};

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_lhs = '0; in_rhs = '0; in_tag = '0;
    out_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1'b0));
    chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
    chk("rst_out_result", 64'(out_result), 64'(0));
    chk("rst_out_tag", 64'(out_tag), 64'(0));
    chk("rst_out_zero", 64'(out_zero), 64'(1'b1));
    chk("rst_out_parity", 64'(out_parity), 64'(1'b0));
    chk("rst_occupancy", 64'(occupancy), 64'(0));
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(in_ready), 64'(1'b1));
    step();

    // Op sweep, compared against fixed expected values at exact latency.
    check_lat = 1'b1;
    for (int i = 0; i < 8 + S; i++) begin
      if (i < 8) drive(3'(i), 32'h0000_00C5, 32'h0000_003A, 4'(i));
      else in_valid = 1'b0;
      @(negedge clk);
      if (i < 8) chk("sweep_in_ready", 64'(in_ready), 64'(1'b1));
      if (i >= S) begin
        chk("sweep_valid", 64'(out_valid), 64'(1'b1));
        chk("sweep_result", 64'(out_result), 64'(sweep_exp[i-S]));
      end
      if (i == S) begin
        chk("sweep_first_zero", 64'(out_zero), 64'(1'b1));
        chk("sweep_first_parity", 64'(out_parity), 64'(1'b0));
      end
      step();
    end
    drain(50);

    // Streaming XOR with tags 0..15.
    for (int i = 0; i < 16; i++) begin
      drive(3'd2, $urandom, $urandom, 4'(i));
      @(negedge clk);
      chk("stream_in_ready", 64'(in_ready), 64'(1'b1));
      step();
    end
    in_valid = 1'b0;
    drain(50);

    // Back-pressure, then simultaneous accept/emit with a full pipe.
    check_lat = 1'b0;
    out_ready = 1'b0;
    drive(3'd0, 32'h0000_F0F0, 32'h0000_FF00, 4'd1);
    @(negedge clk);
    step();
    drive(3'd1, 32'h1234_0000, 32'h0000_5678, 4'd2);
    @(negedge clk);
    step();
    drive(3'd6, 32'hFFFF_0000, 32'h0F0F_0F0F, 4'd3);
    @(negedge clk);
    chk("bp_in_ready", 64'(in_ready), 64'(1'b0));
    chk("bp_occupancy", 64'(occupancy), 64'(2));
    chk("bp_out_valid", 64'(out_valid), 64'(1'b1));
    chk("bp_result", 64'(out_result), 64'(32'h0000_F000));
    chk("bp_tag", 64'(out_tag), 64'(4'd1));
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      chk("bp_hold_result", 64'(out_result), 64'(32'h0000_F000));
      chk("bp_hold_ready", 64'(in_ready), 64'(1'b0));
    end
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_sim_in_ready", 64'(in_ready), 64'(1'b1));
    chk("full_sim_occ_before", 64'(occupancy), 64'(2));
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_sim_occ_after", 64'(occupancy), 64'(2));
    chk("full_sim_tag", 64'(out_tag), 64'(4'd2));
    drain(50);

    // Reset with two operations in flight.
    out_ready = 1'b0;
    drive(3'd2, 32'hDEAD_BEEF, 32'h0000_0001, 4'd5);
    @(negedge clk);
    step();
    drive(3'd4, 32'hAAAA_AAAA, 32'h5555_5555, 4'd6);
    @(negedge clk);
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'(1'b0));
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'(1'b0));
    chk("midrst_occupancy", 64'(occupancy), 64'(0));
    chk("midrst_zero", 64'(out_zero), 64'(1'b1));
    chk("midrst_in_ready_after", 64'(in_ready), 64'(1'b1));
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      chk("midrst_no_stale", 64'(out_valid), 64'(1'b0));
    end
    step();

    // Flag corner cases.
    check_lat = 1'b1;
    drive(3'd2, 32'h0000_0001, 32'h0000_0000, 4'd7);
    @(negedge clk);
    step();
    drive(3'd7, 32'hFFFF_FFFF, 32'h1234_5678, 4'd8);
    @(negedge clk);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("flag_xor_result", 64'(out_result), 64'(32'h0000_0001));
    chk("flag_xor_zero", 64'(out_zero), 64'(1'b0));
    chk("flag_xor_parity", 64'(out_parity), 64'(1'b1));
    step();
    @(negedge clk);
    chk("flag_not_result", 64'(out_result), 64'(32'h0000_0000));
    chk("flag_not_zero", 64'(out_zero), 64'(1'b1));
    chk("flag_not_parity", 64'(out_parity), 64'(1'b0));
    step();
    drain(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
